// File: rtl/uart_com_pkg.sv
// uart_com_pkg: shared types and helpers for the uart_com host link.
//   tx_state_t / rx_state_t : frame state encodings for the TX and RX FSMs.
//   clks_per_bit()          : integer (truncating) baud divisor from the
//                             system clock in kHz and the line rate in bit/s.
package uart_com_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Bit-time counters never get narrower than this.
  localparam int unsigned MIN_CNT_W = 16;

  function automatic int unsigned clks_per_bit(input int unsigned khz,
                                               input int unsigned baud);
    longint unsigned hz;
    hz = longint'(khz) * 64'd1000;
    return int'(hz / longint'(baud));
  endfunction

endpackage

// File: rtl/uart_com_rx.sv
// uart_com_rx: 8N1 receiver for uart_com.
//   system_clock  in   rising-edge clock
//   ext_reset_n   in   asynchronous active-low reset
//   rx            in   raw serial input (asynchronous, idles high)
//   data_rdy      out  one-cycle strobe, new byte on data_received
//   data_received out  last accepted byte, held until the next one
// Configuration macro: UART_COM_FRAMING_CHECK_EN -- when defined, bytes whose
// stop bit samples 0 are dropped; otherwise they are delivered anyway.
module uart_com_rx
  import uart_com_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       system_clock,
  input  logic       ext_reset_n,
  input  logic       rx,
  output logic       data_rdy,
  output logic [7:0] data_received
);

  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rx_meta_q;
  logic             rx_sync_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             rdy_q, rdy_d;
  logic [7:0]       data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    rdy_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      // A start edge only counts once the line has been seen high since the
      // last frame, so a held break cannot retrigger back-to-back frames.
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_sync_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          armed_d = 1'b0;
`ifdef UART_COM_FRAMING_CHECK_EN
          if (rx_sync_q) begin
            rdy_d  = 1'b1;
            data_d = shift_q;
          end
`else
          rdy_d  = 1'b1;
          data_d = shift_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      rdy_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
    end
  end

  assign data_rdy      = rdy_q;
  assign data_received = data_q;

endmodule

// File: rtl/uart_com.sv
// uart_com: full-duplex 8N1 UART, host link of the logic-analyzer top level.
//   system_clock  in   rising-edge clock
//   ext_reset_n   in   asynchronous active-low reset
//   trans_en      in   transmit request (accepted only when idle)
//   data_out      in   byte to send, captured on acceptance
//   Rx            in   serial input (asynchronous, idles high)
//   Tx            out  serial output (idles high)
//   tx_busy       out  high while a frame is on the line
//   data_rdy      out  one-cycle strobe for data_received
//   data_received out  last received byte
// Configuration macro: UART_COM_FRAMING_CHECK_EN (see uart_com_rx).
module uart_com
  import uart_com_pkg::*;
#(
  parameter int unsigned INPUT_CLK_KHZ = 100_000,
  parameter int unsigned BAUD_RATE     = 115200
) (
  input  logic       system_clock,
  input  logic       ext_reset_n,
  input  logic       trans_en,
  input  logic [7:0] data_out,
  input  logic       Rx,
  output logic       Tx,
  output logic       tx_busy,
  output logic       data_rdy,
  output logic [7:0] data_received
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(INPUT_CLK_KHZ, BAUD_RATE);
  localparam int unsigned CNT_W = ($clog2(CLKS_PER_BIT) > MIN_CNT_W) ?
                                  $clog2(CLKS_PER_BIT) : MIN_CNT_W;
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (trans_en) begin
          state_d = TX_START;
          shift_d = data_out;
        end
      end
      TX_START: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line outputs are registered from the current state, so the whole frame
    // appears one cycle after acceptance and busy spans exactly 10 bit times.
    busy_d = (state_q != TX_IDLE);
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign Tx      = tx_q;
  assign tx_busy = busy_q;

  uart_com_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_rx (
    .system_clock (system_clock),
    .ext_reset_n  (ext_reset_n),
    .rx           (Rx),
    .data_rdy     (data_rdy),
    .data_received(data_received)
  );

endmodule

// File: tb/tb_uart_com.sv
// Bench for uart_com, run at a reduced bit time (17 clocks) so many frames fit.
`timescale 1ns/1ps
module tb_uart_com;

  localparam int unsigned KHZ  = 1000;
  localparam int unsigned BAUD = 57600;
  localparam int CPB  = (KHZ * 1000) / BAUD;  // 17, truncated
  localparam int HALF = CPB / 2;
  localparam int GLITCH_LEN = HALF - 3;
`ifdef UART_COM_FRAMING_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trans_en = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       tx, busy, rdy;
  logic [7:0] data_rcv;

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_com #(
    .INPUT_CLK_KHZ(KHZ),
    .BAUD_RATE    (BAUD)
  ) dut (
    .system_clock (clk),
    .ext_reset_n  (rst_n),
    .trans_en     (trans_en),
    .data_out     (data_out),
    .Rx           (rx_line),
    .Tx           (tx),
    .tx_busy      (busy),
    .data_rdy     (rdy),
    .data_received(data_rcv)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_start_cyc = 0;
  int rx_start_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rdy_q[$];
  int         rdy_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      rdy_q.push_back(data_rcv);
      rdy_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reception latency from the driven start edge: 9.5 bit times plus the
  // two-flop synchroniser and registered strobe.
  function automatic logic lat_ok(input int d);
    return (d >= 9 * CPB + HALF) && (d <= 9 * CPB + HALF + 5);
  endfunction

  task automatic send_and_check(input logic [7:0] b, input int rej_at,
                                input logic [9:0] exp_frame, input string nm);
    int bad, extra, k;
    @(posedge clk); #1; trans_en = 1'b1; data_out = b;
    @(posedge clk); #1; trans_en = 1'b0;
    @(posedge clk); #1; tx_start_cyc = cyc;
    for (int bi = 0; bi < 10; bi++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        k = bi * CPB + c;
        if (tx !== exp_frame[bi] || busy !== 1'b1) bad++;
        if (k == rej_at) begin
          trans_en = 1'b1; data_out = 8'hFF;
        end else if (k == rej_at + 1) begin
          trans_en = 1'b0;
        end
        @(posedge clk); #1;
      end
      check($sformatf("%s_bit%0d_badcycles", nm, bi), bad, 0);
    end
    check($sformatf("%s_busy_end", nm), busy, 1'b0);
    check($sformatf("%s_tx_end", nm), tx, 1'b1);
    extra = 0;
    for (int c = 0; c < 2 * CPB; c++) begin
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
      @(posedge clk); #1;
    end
    check($sformatf("%s_idle_after", nm), extra, 0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #1; rx_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  task automatic rx_run(input logic [7:0] b, input logic stop, input logic glitch,
                        input logic exp_rdy, input logic [7:0] exp_data, input string nm);
    rdy_q.delete();
    rdy_cyc.delete();
    if (glitch) begin
      @(posedge clk); #1; rx_drv = 1'b0;
      repeat (GLITCH_LEN) @(posedge clk);
      #1; rx_drv = 1'b1;
    end else begin
      rx_frame(b, stop);
    end
    repeat (2 * CPB) @(posedge clk);
    #1;
    check($sformatf("%s_pulses", nm), rdy_q.size(), {31'd0, exp_rdy});
    if (rdy_q.size() > 0) begin
      check($sformatf("%s_byte", nm), rdy_q[0], exp_data);
      check($sformatf("%s_latency_ok", nm), lat_ok(rdy_cyc[0] - rx_start_cyc), 1'b1);
    end
    check($sformatf("%s_held", nm), data_rcv, exp_data);
    last_good = exp_data;
  endtask

  typedef struct {
    logic [7:0] data;
    int         rej_at;
    logic [9:0] exp_frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    logic       exp_rdy;
    logic [7:0] exp_data;
  } rx_vec_t;

  tx_vec_t tx_tab[5];
  rx_vec_t rx_tab[6];

  initial begin
    logic [7:0] b, b2;
    logic       s, ok;
    int         gap;

    tx_tab[0] = '{8'h55, -1,      10'b1010101010};
    tx_tab[1] = '{8'h55, 3 * CPB, 10'b1010101010};  // second request while busy
    tx_tab[2] = '{8'h00, -1,      10'b1000000000};
    tx_tab[3] = '{8'hFF, -1,      10'b1111111110};
    tx_tab[4] = '{8'h01, -1,      10'b1000000010};

    rx_tab[0] = '{8'hA5, 1'b1, 1'b0, 1'b1,  8'hA5};
    rx_tab[1] = '{8'h3C, 1'b0, 1'b0, !FCHK, FCHK ? 8'hA5 : 8'h3C};
    rx_tab[2] = '{8'h00, 1'b1, 1'b1, 1'b0,  FCHK ? 8'hA5 : 8'h3C};
    rx_tab[3] = '{8'h00, 1'b1, 1'b0, 1'b1,  8'h00};
    rx_tab[4] = '{8'hFF, 1'b1, 1'b0, 1'b1,  8'hFF};
    rx_tab[5] = '{8'h81, 1'b0, 1'b0, !FCHK, FCHK ? 8'hFF : 8'h81};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rdy", rdy, 1'b0);
    check("rst_data", data_rcv, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    foreach (tx_tab[i])
      send_and_check(tx_tab[i].data, tx_tab[i].rej_at, tx_tab[i].exp_frame,
                     $sformatf("txtab%0d", i));

    foreach (rx_tab[i])
      rx_run(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].glitch, rx_tab[i].exp_rdy,
             rx_tab[i].exp_data, $sformatf("rxtab%0d", i));

    // Loopback: the transmitter's own frame is received once.
    loop_en = 1'b1;
    rdy_q.delete();
    rdy_cyc.delete();
    send_and_check(8'hA5, -1, 10'b1101001010, "loop_tx");
    check("loop_pulses", rdy_q.size(), 1);
    if (rdy_q.size() > 0) begin
      check("loop_byte", rdy_q[0], 8'hA5);
      check("loop_latency_ok", lat_ok(rdy_cyc[0] - tx_start_cyc), 1'b1);
    end
    last_good = 8'hA5;

    // trans_en held high: a second frame follows on the first idle cycle.
    rdy_q.delete();
    rdy_cyc.delete();
    @(posedge clk); #1; trans_en = 1'b1; data_out = 8'h12;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) ok = 1'b1;
    end
    check("held_start", ok, 1'b1);
    data_out = 8'h34;
    ok = 1'b0;
    for (int i = 0; i < 12 * CPB && !ok; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) ok = 1'b1;
    end
    check("held_first_end", ok, 1'b1);
    gap = 1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) ok = 1'b1;
      else gap++;
    end
    trans_en = 1'b0;
    check("held_restart", ok, 1'b1);
    check("held_gap_ok", (gap <= 2), 1'b1);
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("held_busy_done", busy, 1'b0);
    check("held_pulses", rdy_q.size(), 2);
    if (rdy_q.size() >= 2) begin
      check("held_byte0", rdy_q[0], 8'h12);
      check("held_byte1", rdy_q[1], 8'h34);
    end
    loop_en = 1'b0;
    last_good = 8'h34;

    // Randomized reception against the framing rules.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if (s || !FCHK) rx_run(b, s, 1'b0, 1'b1, b, $sformatf("rxrnd%0d", i));
      else            rx_run(b, s, 1'b0, 1'b0, last_good, $sformatf("rxrnd%0d", i));
    end

    // Randomized transmission.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_and_check(b, -1, {1'b1, b, 1'b0}, $sformatf("txrnd%0d", i));
    end

    // Simultaneous TX and RX.
    for (int i = 0; i < 4; i++) begin
      b  = 8'($urandom);
      b2 = 8'($urandom);
      fork
        send_and_check(b, -1, {1'b1, b, 1'b0}, $sformatf("dup_tx%0d", i));
        rx_run(b2, 1'b1, 1'b0, 1'b1, b2, $sformatf("dup_rx%0d", i));
      join
    end

    // Reset in the middle of TX bit 4, with an RX frame also in progress.
    rdy_q.delete();
    rdy_cyc.delete();
    @(posedge clk); #1; trans_en = 1'b1; data_out = 8'h55; rx_drv = 1'b0;
    @(posedge clk); #1; trans_en = 1'b0;
    repeat (4 * CPB + HALF) @(posedge clk);
    #1;
    check("midrst_pre_busy", busy, 1'b1);
    #2; rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_data", data_rcv, 8'h00);
    rx_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    last_good = 8'h00;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("midrst_rx_discard", rdy_q.size(), 0);
    check("midrst_idle_busy", busy, 1'b0);
    send_and_check(8'h55, -1, 10'b1010101010, "postrst_tx");
    rx_run(8'h96, 1'b1, 1'b0, 1'b1, 8'h96, "postrst_rx");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_com.md
# uart_com

Full-duplex 8N1 UART serving as the host link of the logic-analyzer top level. The transmitter serialises bytes offered by the metadata sender or the sample FIFO through a mux. The receiver deserialises host command bytes and hands each one to the command decoder with a one-cycle strobe. Baud timing is derived from the system clock by integer division.

## Interface
- INPUT_CLK_KHZ, 100_000: system clock frequency in kHz.
- BAUD_RATE, 115200: line rate in bit/s.
- CLKS_PER_BIT (localparam): (INPUT_CLK_KHZ*1000)/BAUD_RATE, truncated. Defaults give 868.

Ports:
- system_clock  in  1  sole clock. All logic is rising-edge.
- ext_reset_n  in  1  asynchronous, active-low reset.
- trans_en  in  1  transmit request, sampled every cycle.
- data_out  in  8  byte to transmit. Captured when a request is accepted.
- Rx  in  1  serial input. Asynchronous to system_clock; idles high.
- Tx  out  1  serial output; idles high.
- tx_busy  out  1  high while a frame is in progress.
- data_rdy  out  1  one-cycle strobe: a new byte is on data_received.
- data_received  out  8  last received byte. Held until the next valid byte.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX state machine: IDLE, START, DATA, STOP.
  - IDLE -> START when trans_en=1. The same edge latches data_out into a shift register.
  - Each state lasts CLKS_PER_BIT cycles.
  - DATA repeats for 8 bits, tracked by a 3-bit counter.
  - STOP -> IDLE.
- trans_en is ignored outside IDLE; no queueing.
- If trans_en is held high, a new frame starts on the first IDLE cycle after the previous frame ends.
- RX input path: Rx passes through a 2-flop synchroniser before any use.
- RX state machine: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised Rx = 0.
  - START: waits CLKS_PER_BIT/2 cycles, then resamples. If Rx = 1, the start is false: return to IDLE with no output.
  - DATA: samples every CLKS_PER_BIT cycles at mid-bit, shifting LSB first.
  - STOP: samples mid-stop-bit, then returns to IDLE.
- Valid stop bit (1): data_received is updated and data_rdy pulses for exactly one cycle.
- Invalid stop bit (0): handling is selected under Configuration.
- After STOP, RX waits for Rx = 1 before accepting a new start edge. This prevents a break condition from producing back-to-back frames.
- TX and RX are fully independent. Simultaneous operation is required.

## Timing
- Reset values: Tx=1, tx_busy=0, data_rdy=0, data_received=8'h00. Both FSMs are in IDLE and all counters are 0.
- Reset is asynchronous and may arrive mid-frame. It aborts both FSMs immediately and forces Tx high. Any partial RX byte is discarded.
- TX:
  - trans_en accepted on edge N: Tx=0 and tx_busy=1 from edge N+1.
  - tx_busy stays high for exactly 10*CLKS_PER_BIT cycles (8680 at defaults).
  - Tx returns to idle-high, and tx_busy drops, on the same edge.
- RX:
  - Mid-bit sample points fall at (k+0.5)*CLKS_PER_BIT cycles after the synchronised falling edge, k = 0..9.
  - data_rdy asserts one cycle after the stop-bit sample.
  - data_received is stable from the data_rdy cycle onward.
- Bit-time counters are wide enough for CLKS_PER_BIT-1: at least 16 bits. They wrap only under FSM control.
- Baud error from truncation is tolerated: +0.006% at defaults.

## Configuration
- UART_COM_FRAMING_CHECK_EN: controls bytes with a bad (0) stop bit.
  - Defined: the byte is discarded. No data_rdy, and data_received keeps its old value.
  - Undefined: the byte is delivered with data_rdy regardless of the stop-bit value.

## Structure
- Package uart_com_pkg holds:
  - tx_state_t and rx_state_t enums: IDLE, START, DATA, STOP.
  - function clks_per_bit(khz, baud) used by the top level.
- Natural sub-module: uart_com_rx, containing the synchroniser and RX FSM.
- The TX FSM stays inline in uart_com.

## Test plan
- TX byte: trans_en one-cycle pulse with data_out=8'h55.
  - Tx sequence 0,1,0,1,0,1,0,1,0,1, each 868 cycles.
  - tx_busy high for 8680 cycles; Tx=1 after.
- Busy rejection: second trans_en with 8'hFF pulsed 1000 cycles into the frame.
  - The frame still carries 0x55; no second frame follows.
- RX loopback: Tx tied to Rx, send 8'hA5.
  - Exactly one data_rdy pulse, with data_received=8'hA5, about 9.5 bit times after the start edge.
- Glitch rejection: Rx driven low for 300 cycles (< 434), then high.
  - No data_rdy; RX returns to IDLE.
- Framing: drive a frame for 8'h3C with stop bit = 0.
  - With UART_COM_FRAMING_CHECK_EN: no data_rdy, data_received unchanged.
  - Without the macro: data_rdy pulses with 8'h3C.
- Reset mid-frame: assert ext_reset_n low during TX bit 4.
  - Tx=1 and tx_busy=0 immediately.
  - A trans_en after release transmits a complete, correct frame.
